// File: rtl/gate_checker.sv
// gate_checker: drives a 2-input gate through its truth table and counts mismatches on Q.
// Optional GATE_CHECK_STOP_ON_FAIL_EN ends the run at the first mismatching vector.
module gate_checker #(
   parameter int HOLD_CYCLES = 10,
   parameter int GATE_FN     = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       Q,
   output logic       A,
   output logic       B,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [2:0] err_count,
   output logic [1:0] vec_idx
);
   localparam int CW = $clog2(HOLD_CYCLES + 1);
   localparam logic [CW-1:0] LOAD = CW'(HOLD_CYCLES - 1);
`ifdef GATE_CHECK_STOP_ON_FAIL_EN
   localparam bit STOP = 1'b1;
`else
   localparam bit STOP = 1'b0;
`endif
   typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    vec_q, vec_d;
   logic [2:0]    err_q, err_d;
   logic          expected, mism;
   // A/B come straight from the vector index register, so they are registered outputs
   assign A         = vec_q[0];
   assign B         = vec_q[1];
   assign vec_idx   = vec_q;
   assign err_count = err_q;
   assign busy      = (state_q == DRIVE) || (state_q == CHECK);
   assign done      = (state_q == DONE);
   assign pass      = done && (err_q == 3'd0);
   assign expected  = (GATE_FN == 0) ? (A & B) :
                      (GATE_FN == 1) ? (A | B) :
                      (GATE_FN == 2) ? (A ^ B) : ~(A & B);
   assign mism      = (Q != expected);
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      vec_d   = vec_q;
      err_d   = err_q;
      case (state_q)
         IDLE, DONE: if (start) begin
            state_d = DRIVE;
            vec_d   = 2'd0;
            err_d   = 3'd0;
            cnt_d   = LOAD;
         end
         DRIVE: if (cnt_q == '0) state_d = CHECK;
                else cnt_d = cnt_q - 1'b1;
         CHECK: begin
            err_d = (mism && err_q != 3'd4) ? err_q + 3'd1 : err_q;
            if (vec_q == 2'd3 || (STOP && mism)) state_d = DONE;
            else begin
               state_d = DRIVE;
               vec_d   = vec_q + 2'd1;
               cnt_d   = LOAD;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         vec_q   <= 2'd0;
         err_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         vec_q   <= vec_d;
         err_q   <= err_d;
      end
   end
endmodule
